dual_core_mem_arbiter: RTL and testbench

//  Shares one single-ported data/instruction memory between two riscmulticycle cores.

---
 rtl/dual_core_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dual_core_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two multicycle cores.
// Optional busy-timeout abort is compiled in when ARB_TIMEOUT_EN is defined.
module dual_core_mem_arbiter #(
  parameter bit          RESET_LAST     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        c0_mem_en,
  input  logic        c0_mem_read,
  input  logic        c0_mem_write,
  input  logic [31:0] c0_adr,
  input  logic [31:0] c0_wdata,
  input  logic [1:0]  c0_len,
  output logic [31:0] c0_rdata,
  output logic        c0_run,

  input  logic        c1_mem_en,
  input  logic        c1_mem_read,
  input  logic        c1_mem_write,
  input  logic [31:0] c1_adr,
  input  logic [31:0] c1_wdata,
  input  logic [1:0]  c1_len,
  output logic [31:0] c1_rdata,
  output logic        c1_run,

  output logic        mem_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_len,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,

  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arbState_e;

  arbState_e   state;
  arbState_e   nextState;
  logic        grant;
  logic        lastGrant;
  logic        winner;
  logic        startAccess;
  logic        finishAccess;
  logic        timeoutHit;
  logic        loadRdata;
  logic [31:0] rdataLoad;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gTimeoutRange
    $error("dual_core_mem_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] busyCount;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    nextState    = state;
    winner       = 1'b0;
    startAccess  = 1'b0;
    finishAccess = 1'b0;
    timeoutHit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (c0_mem_en || c1_mem_en) begin
          startAccess = 1'b1;
          // On a tie the core that was not served last goes first.
          winner      = (c0_mem_en && c1_mem_en) ? ~lastGrant : c1_mem_en;
          nextState   = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          finishAccess = 1'b1;
          nextState    = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (busyCount == TIMEOUT_LAST) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
`endif
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Writes never touch the read-data registers; an aborted access returns a marker value.
  assign loadRdata = (finishAccess && mem_read) || timeoutHit;
  assign rdataLoad = timeoutHit ? 32'hDEADBEEF : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= 1'b0;
      lastGrant <= RESET_LAST;
      mem_en    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_len   <= '0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
    end else if (startAccess) begin
      grant     <= winner;
      mem_en    <= 1'b1;
      mem_read  <= winner ? c1_mem_read  : c0_mem_read;
      mem_write <= winner ? c1_mem_write : c0_mem_write;
      mem_adr   <= winner ? c1_adr       : c0_adr;
      mem_wdata <= winner ? c1_wdata     : c0_wdata;
      mem_len   <= winner ? c1_len       : c0_len;
    end else if (finishAccess || timeoutHit) begin
      lastGrant <= grant;
      mem_en    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_len   <= '0;
      if (loadRdata) begin
        if (grant) c1_rdata <= rdataLoad;
        else       c0_rdata <= rdataLoad;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                busyCount <= '0;
    else if (startAccess)   busyCount <= '0;
    else if (state == BUSY) busyCount <= busyCount + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             arb_timeout <= 1'b0;
    else if (timeoutHit) arb_timeout <= 1'b1;
  end
`else
  assign arb_timeout = 1'b0;
`endif

  // A requesting core stays frozen until the single DONE cycle of its own access.
  assign c0_run = !c0_mem_en || (state == DONE && grant == 1'b0);
  assign c1_run = !c1_mem_en || (state == DONE && grant == 1'b1);

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed self-checking bench for dual_core_mem_arbiter; expected values are hand-computed.
// The timeout abort scenario is exercised when ARB_TIMEOUT_EN is defined.
module tb_dual_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_mem_en, c0_mem_read, c0_mem_write;
  logic [31:0] c0_adr, c0_wdata, c0_rdata;
  logic [1:0]  c0_len;
  logic        c0_run;
  logic        c1_mem_en, c1_mem_read, c1_mem_write;
  logic [31:0] c1_adr, c1_wdata, c1_rdata;
  logic [1:0]  c1_len;
  logic        c1_run;
  logic        mem_en, mem_read, mem_write;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [1:0]  mem_len;
  logic        mem_ready;
  logic        arb_timeout;

  int vecCount  = 0;
  int missCount = 0;

  dual_core_mem_arbiter #(.RESET_LAST(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .c0_mem_en(c0_mem_en), .c0_mem_read(c0_mem_read), .c0_mem_write(c0_mem_write),
    .c0_adr(c0_adr), .c0_wdata(c0_wdata), .c0_len(c0_len), .c0_rdata(c0_rdata), .c0_run(c0_run),
    .c1_mem_en(c1_mem_en), .c1_mem_read(c1_mem_read), .c1_mem_write(c1_mem_write),
    .c1_adr(c1_adr), .c1_wdata(c1_wdata), .c1_len(c1_len), .c1_rdata(c1_rdata), .c1_run(c1_run),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic runOf(input int core);
    return (core == 1) ? c1_run : c0_run;
  endfunction

  function automatic logic [31:0] rdataOf(input int core);
    return (core == 1) ? c1_rdata : c0_rdata;
  endfunction

  function automatic logic enOf(input int core);
    return (core == 1) ? c1_mem_en : c0_mem_en;
  endfunction

  task automatic req(input int core, input logic isWrite, input logic [31:0] adr,
                     input logic [31:0] wdata, input logic [1:0] len);
    if (core == 1) begin
      c1_mem_en = 1'b1; c1_mem_read = !isWrite; c1_mem_write = isWrite;
      c1_adr = adr; c1_wdata = wdata; c1_len = len;
    end else begin
      c0_mem_en = 1'b1; c0_mem_read = !isWrite; c0_mem_write = isWrite;
      c0_adr = adr; c0_wdata = wdata; c0_len = len;
    end
  endtask

  task automatic release_core(input int core);
    if (core == 1) begin
      c1_mem_en = 1'b0; c1_mem_read = 1'b0; c1_mem_write = 1'b0;
    end else begin
      c0_mem_en = 1'b0; c0_mem_read = 1'b0; c0_mem_write = 1'b0;
    end
  endtask

  // Called with the arbiter in IDLE and the expected winner's request already driven.
  task automatic access(input string tag, input int core, input logic [31:0] adr,
                        input logic [31:0] wdata, input logic [1:0] len, input logic isWrite,
                        input int waits, input logic [31:0] rd, input logic [31:0] expRdata,
                        input logic drop);
    int other;
    other = 1 - core;
    tick();
    check({tag, ".busy.en"},    mem_en,    1'b1);
    check({tag, ".busy.adr"},   mem_adr,   adr);
    check({tag, ".busy.write"}, mem_write, isWrite);
    check({tag, ".busy.read"},  mem_read,  !isWrite);
    check({tag, ".busy.wdata"}, mem_wdata, wdata);
    check({tag, ".busy.len"},   mem_len,   len);
    check({tag, ".busy.run"},   runOf(core), 1'b0);
    check({tag, ".busy.orun"},  runOf(other), !enOf(other));
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, ".wait.en"},    mem_en,    1'b1);
      check({tag, ".wait.adr"},   mem_adr,   adr);
      check({tag, ".wait.wdata"}, mem_wdata, wdata);
      check({tag, ".wait.run"},   runOf(core), 1'b0);
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".done.en"},    mem_en,  1'b0);
    check({tag, ".done.adr"},   mem_adr, 32'h0);
    check({tag, ".done.run"},   runOf(core), 1'b1);
    check({tag, ".done.orun"},  runOf(other), !enOf(other));
    check({tag, ".done.rdata"}, rdataOf(core), expRdata);
    if (drop) release_core(core);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    c0_mem_en = 1'b0; c0_mem_read = 1'b0; c0_mem_write = 1'b0;
    c0_adr = '0; c0_wdata = '0; c0_len = '0;
    c1_mem_en = 1'b0; c1_mem_read = 1'b0; c1_mem_write = 1'b0;
    c1_adr = '0; c1_wdata = '0; c1_len = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_en",   mem_en,      1'b0);
    check("rst.mem_adr",  mem_adr,     32'h0);
    check("rst.c0_rdata", c0_rdata,    32'h0);
    check("rst.c1_rdata", c1_rdata,    32'h0);
    check("rst.c0_run",   c0_run,      1'b1);
    check("rst.c1_run",   c1_run,      1'b1);
    check("rst.timeout",  arb_timeout, 1'b0);
    rst = 1'b0;
    tick();

    // mem_ready while IDLE must not start or complete anything
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check("idle_ready.en",    mem_en,   1'b0);
    check("idle_ready.rdata", c0_rdata, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    // Single read from core 0, then an immediate re-request with core 1 idle
    req(0, 1'b0, 32'h0000_0100, 32'h0, 2'b10);
    #1;
    check("t1.req.c0_run", c0_run, 1'b0);
    check("t1.req.c1_run", c1_run, 1'b1);
    access("t1", 0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    req(0, 1'b0, 32'h0000_0104, 32'h0, 2'b10);
    access("t1b", 0, 32'h0000_0104, 32'h0, 2'b10, 1'b0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);

    // Simultaneous requests right after reset: core 0 first, core 1 waits frozen
    rst = 1'b1;
    #1;
    check("t2.rst.c0_rdata", c0_rdata, 32'h0);
    rst = 1'b0;
    tick();
    req(0, 1'b0, 32'h0000_0010, 32'h0, 2'b10);
    req(1, 1'b0, 32'h0000_0020, 32'h0, 2'b01);
    access("t2.c0", 0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 0, 32'h1111_0000, 32'h1111_0000, 1'b1);
    check("t2.idle.c1_run", c1_run, 1'b0);
    access("t2.c1", 1, 32'h0000_0020, 32'h0, 2'b01, 1'b0, 0, 32'h2222_0000, 32'h2222_0000, 1'b1);
    check("t2.c0_rdata_kept", c0_rdata, 32'h1111_0000);

    // Core 1 byte write with three wait states; its read data must not change
    req(1, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 2'b00);
    access("t3", 1, 32'h0000_0200, 32'hA5A5_A5A5, 2'b00, 1'b1, 3, 32'hFFFF_0000, 32'h2222_0000, 1'b1);

    // Continuous contention: grants alternate 0,1,0,1,0,1 (core 1 was served last)
    req(0, 1'b0, 32'h0000_0300, 32'h0, 2'b10);
    req(1, 1'b0, 32'h0000_0400, 32'h0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      int core;
      logic [31:0] rd;
      core = i % 2;
      rd   = 32'h4000_0000 + 32'(i);
      access($sformatf("t4.%0d", i), core, (core == 1) ? 32'h0000_0400 : 32'h0000_0300,
             32'h0, 2'b10, 1'b0, 0, rd, rd, (i >= 4));
    end

    // Reset in the middle of a core 1 access
    req(1, 1'b0, 32'h0000_0500, 32'h0, 2'b10);
    tick();
    check("t5.busy.en", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    check("t5.rst.en",       mem_en,   1'b0);
    check("t5.rst.adr",      mem_adr,  32'h0);
    check("t5.rst.c0_rdata", c0_rdata, 32'h0);
    check("t5.rst.c1_rdata", c1_rdata, 32'h0);
    #1;
    rst = 1'b0;
    req(0, 1'b0, 32'h0000_0600, 32'h0, 2'b10);
    tick();
    access("t5.c0", 0, 32'h0000_0600, 32'h0, 2'b10, 1'b0, 0, 32'h6666_6666, 32'h6666_6666, 1'b1);
    access("t5.c1", 1, 32'h0000_0500, 32'h0, 2'b10, 1'b0, 0, 32'h5555_5555, 32'h5555_5555, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after four BUSY cycles
    req(0, 1'b0, 32'h0000_0700, 32'h0, 2'b10);
    tick();
    check("t6.busy1.en", mem_en, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6.busy.en",      mem_en,      1'b1);
      check("t6.busy.timeout", arb_timeout, 1'b0);
    end
    tick();
    check("t6.done.en",      mem_en,      1'b0);
    check("t6.done.rdata",   c0_rdata,    32'hDEAD_BEEF);
    check("t6.done.timeout", arb_timeout, 1'b1);
    check("t6.done.run",     c0_run,      1'b1);
    release_core(0);
    tick();
    tick();
    check("t6.sticky", arb_timeout, 1'b1);
    rst = 1'b1;
    #1;
    check("t6.rst.timeout", arb_timeout, 1'b0);
    rst = 1'b0;
    tick();
`else
    // Without the timeout option a silent memory just stretches BUSY
    req(0, 1'b0, 32'h0000_0700, 32'h0, 2'b10);
    access("t6", 0, 32'h0000_0700, 32'h0, 2'b10, 1'b0, 10, 32'h7777_7777, 32'h7777_7777, 1'b1);
    check("t6.timeout", arb_timeout, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
